br_dispatch_op: RTL and testbench

Conditional-branch dispatcher consuming the 1-bit predicate produced by the compare operators. It takes an activation token for its basic block, waits for a valid branch condition, then issues exactly one successor token (true or false path) and holds it until the selected successor accepts. It sits between the compare datapath and the basic-block enable chain of the generated control FSM.

---
 rtl/br_dispatch_op.sv | 98 +++++++++
 tb/tb_br_dispatch_op.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/br_dispatch_op.sv
// Conditional-branch dispatcher: turns a block activation token plus a compare predicate into
// exactly one held successor token. Optional branch statistics are built with BR_DISPATCH_STATS_EN.
module br_dispatch_op #(
   parameter int unsigned ParamCountWidth = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       cond,
   input  logic                       cond_valid,
   input  logic                       succ_ready,
   output logic                       token_true,
   output logic                       token_false,
   output logic                       busy,
   output logic                       err_overrun,
   output logic [ParamCountWidth-1:0] taken_cnt,
   output logic [ParamCountWidth-1:0] not_taken_cnt
);

   typedef enum logic [1:0] {StIdle, StWaitCond, StDispatch} state_e;

   state_e state_q, state_d;
   logic   cond_q, cond_d;
   logic   err_q, err_d;

   always_comb begin
      state_d = state_q;
      cond_d  = cond_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (enable) begin
               if (cond_valid) begin
                  cond_d  = cond;
                  state_d = StDispatch;
               end else begin
                  state_d = StWaitCond;
               end
            end
         end
         StWaitCond: begin
            if (enable) err_d = 1'b1;
            if (cond_valid) begin
               cond_d  = cond;
               state_d = StDispatch;
            end
         end
         StDispatch: begin
            // An enable coinciding with acceptance is still an overrun: the block is busy this cycle.
            if (enable) err_d = 1'b1;
            if (succ_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cond_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cond_q  <= cond_d;
         err_q   <= err_d;
      end
   end

   // Outputs decode registered state only, so they never follow inputs combinationally.
   assign token_true  = (state_q == StDispatch) &  cond_q;
   assign token_false = (state_q == StDispatch) & ~cond_q;
   assign busy        = (state_q != StIdle);
   assign err_overrun = err_q;

`ifdef BR_DISPATCH_STATS_EN
   logic                       accept;
   logic [ParamCountWidth-1:0] taken_q, not_taken_q;

   assign accept = (state_q == StDispatch) & succ_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         taken_q     <= '0;
         not_taken_q <= '0;
      end else if (accept) begin
         if (cond_q && (taken_q != '1)) taken_q <= taken_q + ParamCountWidth'(1);
         if (!cond_q && (not_taken_q != '1)) not_taken_q <= not_taken_q + ParamCountWidth'(1);
      end
   end

   assign taken_cnt     = taken_q;
   assign not_taken_cnt = not_taken_q;
`else
   assign taken_cnt     = '0;
   assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_br_dispatch_op.sv
// Scoreboard bench for br_dispatch_op: expected branch directions are queued at enable and
// compared when the successor token is accepted.
module tb_br_dispatch_op;

   localparam int unsigned CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable, cond, cond_valid, succ_ready;
   logic          token_true, token_false, busy, err_overrun;
   logic [CW-1:0] taken_cnt, not_taken_cnt;

   int            errors = 0;
   int            checks = 0;
   logic          exp_q[$];
   int            exp_t = 0;
   int            exp_f = 0;
   logic          exp_err = 1'b0;

   br_dispatch_op #(.ParamCountWidth(CW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cond(cond), .cond_valid(cond_valid),
      .succ_ready(succ_ready), .token_true(token_true), .token_false(token_false), .busy(busy),
      .err_overrun(err_overrun), .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag);
      check({tag, "_err"}, {31'd0, err_overrun}, {31'd0, exp_err});
      check({tag, "_taken"}, {30'd0, taken_cnt}, exp_t);
      check({tag, "_not_taken"}, {30'd0, not_taken_cnt}, exp_f);
   endtask

   task automatic count(input logic c);
`ifdef BR_DISPATCH_STATS_EN
      if (c && exp_t < 3) exp_t++;
      if (!c && exp_f < 3) exp_f++;
`endif
   endtask

   // One transaction from IDLE: wait_n cycles until cond_valid, hold_n cycles of succ_ready low,
   // optional enable pulse at waiting step ovr_at, optional enable at the accepting edge.
   task automatic dispatch(input logic c, input int wait_n, input int hold_n, input int ovr_at,
                           input bit en_at_accept);
      logic e;
      enable     = 1'b1;
      cond_valid = (wait_n == 0);
      cond       = c;
      succ_ready = 1'b0;
      exp_q.push_back(c);
      tick();
      enable = 1'b0;
      check("busy_after_enable", {31'd0, busy}, 32'd1);
      for (int i = 0; i < wait_n; i++) begin
         cond_valid = (i == wait_n - 1);
         cond       = (i == wait_n - 1) ? c : ~c;
         enable     = (i == ovr_at);
         if (i == ovr_at) exp_err = 1'b1;
         tick();
         enable = 1'b0;
         if (i == ovr_at) check("err_set", {31'd0, err_overrun}, 32'd1);
         if (i < wait_n - 1) check("no_token_waiting", {30'd0, token_true, token_false}, 32'd0);
      end
      // Predicate noise while dispatching must be ignored.
      for (int i = 0; i < hold_n; i++) begin
         cond_valid = 1'b1;
         cond       = ~c;
         tick();
         if (exp_q.size() != 0) check("token_held", {31'd0, token_true}, {31'd0, exp_q[0]});
      end
      cond_valid = 1'b0;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check("token_true", {31'd0, token_true}, {31'd0, e});
         check("token_false", {31'd0, token_false}, {31'd0, !e});
      end
      succ_ready = 1'b1;
      enable     = en_at_accept;
      if (en_at_accept) exp_err = 1'b1;
      tick();
      succ_ready = 1'b0;
      enable     = 1'b0;
      count(c);
      check("busy_after_accept", {31'd0, busy}, 32'd0);
      check("tokens_after_accept", {30'd0, token_true, token_false}, 32'd0);
      check_status("post");
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; cond = 1'b0; cond_valid = 1'b0; succ_ready = 1'b0;
      #12;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_tokens", {30'd0, token_true, token_false}, 32'd0);
      check_status("reset");
      rst_n = 1'b1;
      tick();

      // Simple true dispatch, successor already ready.
      succ_ready = 1'b1;
      dispatch(1'b1, 0, 0, -1, 1'b0);
      // False path: cond_valid three edges later, successor stalls three cycles.
      dispatch(1'b0, 3, 3, -1, 1'b0);
      // Overrun while waiting for the predicate; sticky across later dispatches.
      dispatch(1'b1, 3, 1, 1, 1'b0);
      dispatch(1'b0, 1, 0, -1, 1'b0);
      check("err_sticky", {31'd0, err_overrun}, 32'd1);

      // Predicate pulses in IDLE without enable do nothing.
      for (int i = 0; i < 4; i++) begin
         cond_valid = i[0];
         cond       = 1'b1;
         succ_ready = i[1];
         tick();
         check("idle_busy", {31'd0, busy}, 32'd0);
         check("idle_tokens", {30'd0, token_true, token_false}, 32'd0);
      end
      cond_valid = 1'b0;

      // Reset mid-DISPATCH discards the pending token.
      enable = 1'b1; cond_valid = 1'b1; cond = 1'b1; succ_ready = 1'b0;
      exp_q.push_back(1'b1);
      tick();
      enable = 1'b0; cond_valid = 1'b0;
      check("token_before_reset", {31'd0, token_true}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_err = 1'b0; exp_t = 0; exp_f = 0;
      check("rst_tokens", {30'd0, token_true, token_false}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check_status("rst");
      @(negedge clk) rst_n = 1'b1;
      succ_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("no_token_after_rst", {30'd0, token_true, token_false}, 32'd0);
      end

      // Back-to-back true dispatches saturate the 2-bit counter.
      for (int i = 0; i < 5; i++) dispatch(1'b1, 0, 0, -1, 1'b0);
`ifdef BR_DISPATCH_STATS_EN
      check("taken_saturated", {30'd0, taken_cnt}, 32'd3);
`else
      check("taken_tied_off", {30'd0, taken_cnt}, 32'd0);
`endif
      // Enable on the accepting edge is an overrun, FSM still returns to IDLE.
      dispatch(1'b0, 0, 2, -1, 1'b1);
      dispatch(1'b0, 2, 0, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
